// File: rtl/multi_data_bypass_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_data_bypass_pkg: default parameters and delay-clamp helper       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package multi_data_bypass_pkg;

  localparam int DEF_NUM_CH    = 2;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_DEPTH = 8;

  // Zero and out-of-range requests fall back to the deepest delay.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned max_depth);
    return ((req == 0) || (req > max_depth)) ? max_depth : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/multi_data_bypass_channel.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mdb_channel: one delay-line channel with tap select, inflight count,   |
// | act_delay tracking; DATA_BYPASS_ERR_INJ_EN adds error injection.       |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module mdb_channel
  import multi_data_bypass_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int DLY_W     = $clog2(DEF_MAX_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [DLY_W-1:0]  cfg_delay_i,
  input  logic              flush_i,
`ifdef DATA_BYPASS_ERR_INJ_EN
  input  logic              err_inj_i,
  output logic [15:0]       err_cnt_o,
`endif
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [DLY_W-1:0]  inflight_o,
  output logic [DLY_W-1:0]  act_delay_o
);

  logic [MAX_DEPTH:1] vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q [1:MAX_DEPTH];
  logic [DLY_W-1:0]   inflight_q, inflight_d;
  logic [DLY_W-1:0]   act_q, act_d;
  logic               accept;
  logic               tap_vld;
  logic [DATA_W-1:0]  tap_dat;

  assign accept = in_valid_i & ~flush_i;

  always_comb begin
    tap_vld = 1'b0;
    tap_dat = '0;
    for (int k = 1; k <= MAX_DEPTH; k++) begin
      if (act_q == DLY_W'(k)) begin
        tap_vld = vld_q[k];
        tap_dat = dat_q[k];
      end
    end
  end

  // Beats past the tap are dropped so a later, longer delay never sees stale valids.
  always_comb begin
    vld_d = '0;
    if (!flush_i) begin
      vld_d[1] = accept;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        vld_d[k] = vld_q[k-1] && (DLY_W'(k) <= act_q);
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush_i) begin
      inflight_d = '0;
    end else if (accept && !tap_vld) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && tap_vld) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_comb begin
    act_d = act_q;
    if ((inflight_q == '0) && !accept) begin
      act_d = DLY_W'(clamp_delay(32'(cfg_delay_i), MAX_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
      act_q      <= DLY_W'(MAX_DEPTH);
      for (int k = 1; k <= MAX_DEPTH; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
      act_q      <= act_d;
      dat_q[1]   <= in_data_i;
      for (int k = 2; k <= MAX_DEPTH; k++) begin
        dat_q[k] <= dat_q[k-1];
      end
    end
  end

`ifdef DATA_BYPASS_ERR_INJ_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (tap_vld && err_inj_i && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign out_data_o = tap_vld ? (err_inj_i ? {DATA_W{1'b1}} : tap_dat) : '0;
`else
  assign out_data_o = tap_vld ? tap_dat : '0;
`endif

  assign out_valid_o = tap_vld;
  assign inflight_o  = inflight_q;
  assign act_delay_o = act_q;

endmodule
`default_nettype wire

// File: rtl/multi_data_bypass.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | multi_data_bypass: NUM_CH independent programmable-delay bypass lanes. |
// | Optional macro DATA_BYPASS_ERR_INJ_EN adds err_inj / err_cnt ports.    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module multi_data_bypass
  import multi_data_bypass_pkg::*;
#(
  parameter  int NUM_CH    = DEF_NUM_CH,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int MAX_DEPTH = DEF_MAX_DEPTH,
  localparam int DLY_W     = $clog2(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*DLY_W-1:0]  cfg_delay,
  input  logic [NUM_CH-1:0]        flush,
`ifdef DATA_BYPASS_ERR_INJ_EN
  input  logic [NUM_CH-1:0]        err_inj,
  output logic [NUM_CH*16-1:0]     err_cnt,
`endif
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*DLY_W-1:0]  inflight,
  output logic [NUM_CH*DLY_W-1:0]  act_delay
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mdb_channel #(
      .DATA_W    (DATA_W),
      .MAX_DEPTH (MAX_DEPTH),
      .DLY_W     (DLY_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (in_valid[c]),
      .in_data_i   (in_data[c*DATA_W +: DATA_W]),
      .cfg_delay_i (cfg_delay[c*DLY_W +: DLY_W]),
      .flush_i     (flush[c]),
`ifdef DATA_BYPASS_ERR_INJ_EN
      .err_inj_i   (err_inj[c]),
      .err_cnt_o   (err_cnt[c*16 +: 16]),
`endif
      .out_valid_o (out_valid[c]),
      .out_data_o  (out_data[c*DATA_W +: DATA_W]),
      .inflight_o  (inflight[c*DLY_W +: DLY_W]),
      .act_delay_o (act_delay[c*DLY_W +: DLY_W])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_data_bypass.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_multi_data_bypass: directed + random stimulus against a due-time    |
// | queue model of each channel.                                           |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_multi_data_bypass;

  localparam int NUM_CH    = 2;
  localparam int DATA_W    = 64;
  localparam int MAX_DEPTH = 8;
  localparam int DLY_W     = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_CH-1:0]        in_valid = '0;
  logic [NUM_CH*DATA_W-1:0] in_data = '0;
  logic [NUM_CH*DLY_W-1:0]  cfg_delay = '0;
  logic [NUM_CH-1:0]        flush = '0;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [NUM_CH*DLY_W-1:0]  inflight;
  logic [NUM_CH*DLY_W-1:0]  act_delay;
`ifdef DATA_BYPASS_ERR_INJ_EN
  logic [NUM_CH-1:0]        err_inj = '0;
  logic [NUM_CH*16-1:0]     err_cnt;
  int                       m_err [NUM_CH];
`endif

  multi_data_bypass #(
    .NUM_CH    (NUM_CH),
    .DATA_W    (DATA_W),
    .MAX_DEPTH (MAX_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .cfg_delay (cfg_delay),
    .flush     (flush),
`ifdef DATA_BYPASS_ERR_INJ_EN
    .err_inj   (err_inj),
    .err_cnt   (err_cnt),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .inflight  (inflight),
    .act_delay (act_delay)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [63:0] data;
  } beat_t;

  beat_t mq [NUM_CH][$];
  int    m_act [NUM_CH];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    return ((v == 0) || (v > MAX_DEPTH)) ? MAX_DEPTH : v;
  endfunction

  function automatic bit exp_valid(input int c);
    return (mq[c].size() > 0) && (mq[c][0].due == cyc);
  endfunction

  function automatic int get_inf(input int c);
    return int'(inflight[c*DLY_W +: DLY_W]);
  endfunction

  function automatic int get_act(input int c);
    return int'(act_delay[c*DLY_W +: DLY_W]);
  endfunction

  function automatic logic [63:0] get_dat(input int c);
    return out_data[c*DATA_W +: DATA_W];
  endfunction

  task automatic set_cfg(input int c, input int v);
    cfg_delay[c*DLY_W +: DLY_W] = DLY_W'(v);
  endtask

  task automatic set_dat(input int c, input logic [63:0] v);
    in_data[c*DATA_W +: DATA_W] = v;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mq[c].delete();
      m_act[c] = MAX_DEPTH;
`ifdef DATA_BYPASS_ERR_INJ_EN
      m_err[c] = 0;
`endif
    end
  endtask

  task automatic compare_cycle();
    for (int c = 0; c < NUM_CH; c++) begin
      bit          ev;
      logic [63:0] ed;
      ev = exp_valid(c);
      ed = ev ? mq[c][0].data : 64'd0;
`ifdef DATA_BYPASS_ERR_INJ_EN
      if (ev && err_inj[c]) ed = '1;
      chk($sformatf("err_cnt[%0d]", c), 64'(err_cnt[c*16 +: 16]), 64'(m_err[c]));
`endif
      chk($sformatf("out_valid[%0d]", c), 64'(out_valid[c]), 64'(ev));
      chk($sformatf("out_data[%0d]", c), get_dat(c), ed);
      chk($sformatf("inflight[%0d]", c), 64'(get_inf(c)), 64'(mq[c].size()));
      chk($sformatf("act_delay[%0d]", c), 64'(get_act(c)), 64'(m_act[c]));
    end
  endtask

  task automatic advance();
    for (int c = 0; c < NUM_CH; c++) begin
      bit ev;
      bit acc;
      int sz;
      ev  = exp_valid(c);
      sz  = mq[c].size();
      acc = in_valid[c] && !flush[c];
`ifdef DATA_BYPASS_ERR_INJ_EN
      if (ev && err_inj[c] && (m_err[c] != 65535)) m_err[c]++;
`endif
      if (ev) void'(mq[c].pop_front());
      if (flush[c]) mq[c].delete();
      else if (acc) mq[c].push_back('{due: cyc + m_act[c], data: in_data[c*DATA_W +: DATA_W]});
      if ((sz == 0) && !acc) m_act[c] = clamp(int'(cfg_delay[c*DLY_W +: DLY_W]));
    end
    cyc++;
  endtask

  // Inputs are set at posedge+1; outputs are compared at the negedge.
  task automatic step();
    @(negedge clk);
    compare_cycle();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = '0;
    flush    = '0;
    #2;
    model_reset();
    compare_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    int seen;
    int at_cyc;
    int n;
    int peak;
    logic [63:0] d29;

    model_reset();
    repeat (2) @(negedge clk);
    compare_cycle();
    chk("rst_act0", 64'(get_act(0)), 64'd8);
    chk("rst_inflight1", 64'(get_inf(1)), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;

    // Single beat, default delay: visible only at cycle 8.
    seen = 0; at_cyc = -1; d29 = '0;
    for (int i = 0; i < 12; i++) begin
      in_valid[0] = (i == 0);
      set_dat(0, (i == 0) ? 64'h1234 : 64'hDEAD);
      if (out_valid[0]) begin seen++; at_cyc = i; d29 = get_dat(0); end
      step();
    end
    chk("t029_count", 64'(seen), 64'd1);
    chk("t029_cycle", 64'(at_cyc), 64'd8);
    chk("t029_data", d29, 64'h1234);

    // Delay 3 on ch1, five back-to-back beats.
    in_valid = '0;
    set_cfg(1, 3);
    step();
    n = 0; peak = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = (i < 5);
      set_dat(1, 64'(i + 1));
      if (get_inf(1) > peak) peak = get_inf(1);
      if (out_valid[1]) begin
        chk("t030_data", get_dat(1), 64'(n + 1));
        chk("t030_cycle", 64'(i), 64'(3 + n));
        n++;
      end
      step();
    end
    chk("t030_count", 64'(n), 64'd5);
    chk("t030_peak", 64'(peak), 64'd3);

    // Delay change 8 -> 2 while beats are in flight.
    in_valid = '0;
    set_cfg(0, 8);
    n = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid[0] = (i < 4);
      set_dat(0, 64'(8'hA0 + i));
      if (i == 2) set_cfg(0, 2);
      if (get_inf(0) != 0) chk("t031_hold", 64'(get_act(0)), 64'd8);
      if (out_valid[0]) begin
        chk("t031_order", get_dat(0), 64'(8'hA0 + n));
        n++;
      end
      step();
    end
    chk("t031_count", 64'(n), 64'd4);
    chk("t031_newact", 64'(get_act(0)), 64'd2);

    // Flush ch0 with 6 in flight while ch1 keeps streaming.
    in_valid = '0;
    set_cfg(0, 8);
    step();
    n = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid[0] = (i <= 6);
      flush[0]    = (i == 6);
      set_dat(0, 64'(12'hC00 + i));
      in_valid[1] = (i < 10);
      set_dat(1, 64'(12'hB00 + i));
      if (i == 6) chk("t032_inflight_pre", 64'(get_inf(0)), 64'd6);
      if (i > 6) begin
        chk("t032_ov0", 64'(out_valid[0]), 64'd0);
        chk("t032_inf0", 64'(get_inf(0)), 64'd0);
      end
      if (out_valid[1]) n++;
      step();
    end
    flush = '0;
    in_valid = '0;
    chk("t032_ch1_count", 64'(n), 64'd10);

    // Clamp of 0 and 15.
    set_cfg(0, 3); step(); step();
    chk("t033_act3", 64'(get_act(0)), 64'd3);
    set_cfg(0, 15); step(); step();
    chk("t033_act15", 64'(get_act(0)), 64'd8);
    set_cfg(0, 3); step(); step();
    set_cfg(0, 0); step(); step();
    chk("t033_act0", 64'(get_act(0)), 64'd8);

`ifdef DATA_BYPASS_ERR_INJ_EN
    // Injection on ch1 only; ch0 data passes untouched.
    err_inj = 2'b10;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i == 0) ? 2'b11 : 2'b00;
      set_dat(0, 64'h5555);
      set_dat(1, 64'h7777);
      if (i == 3) chk("t034_ch1_ones", get_dat(1), '1);
      if (i == 8) chk("t034_ch0_data", get_dat(0), 64'h5555);
      step();
    end
    chk("t034_cnt1", 64'(err_cnt[31:16]), 64'd1);
    chk("t034_cnt0", 64'(err_cnt[15:0]), 64'd0);
    err_inj = '0;
`endif

    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) begin
        do_reset();
        in_valid = 2'b11;
        set_dat(0, 64'h0F0F);
        set_dat(1, 64'hF0F0);
        step();
      end
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = ($urandom_range(0, 3) != 0);
        flush[c]    = ($urandom_range(0, 31) == 0);
        set_dat(c, {$urandom, $urandom});
        if ($urandom_range(0, 15) == 0) set_cfg(c, int'($urandom_range(0, 15)));
`ifdef DATA_BYPASS_ERR_INJ_EN
        err_inj[c] = ($urandom_range(0, 7) == 0);
`endif
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
